// File: rtl/cv32e40p_perm_fault_tracker_ft.sv
// Permanent-fault tracker for the replicated EX-stage ALUs.
// Each (channel, operation class) pair has a leaky-bucket error counter.
// When a counter reaches THRESHOLD, the pair gets a sticky fault flag and
// the channel raises a one-cycle perf event.
// Optional feature: define CV32E40P_PERM_FAULT_CLEAR_EN to enable the
// synchronous soft clear through clear_i. Without it, clear_i is ignored.
module cv32e40p_perm_fault_tracker_ft #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned N_CLASS   = 9,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned INC       = 1,
    parameter int unsigned DEC       = 2,
    parameter int unsigned THRESHOLD = 101,
    localparam int unsigned CLASS_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            valid_i,
    input  logic [N_CH*CLASS_W-1:0]    class_i,
    input  logic [N_CH-1:0]            error_i,
    input  logic                       clear_i,
    output logic [N_CH*N_CLASS-1:0]    permanent_faulty_o,
    output logic [N_CH-1:0]            channel_faulty_o,
    output logic [N_CH-1:0]            perf_event_o
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0]                  cnt_q [N_CH][N_CLASS];
    logic [CNT_W-1:0]                  cnt_d [N_CH][N_CLASS];
    logic [N_CH-1:0][N_CLASS-1:0]      flag_q;
    logic [N_CH-1:0][N_CLASS-1:0]      flag_d;
    logic [N_CH-1:0]                   perf_q;
    logic [N_CH-1:0]                   perf_d;
    logic [CLASS_W-1:0]                cls;
    logic [31:0]                       cur;
    logic [31:0]                       upd;

`ifndef CV32E40P_PERM_FAULT_CLEAR_EN
    logic clear_unused;
    assign clear_unused = clear_i;
`endif

    // Next counter/flag state: only the addressed, not-yet-faulty pair of each channel moves
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        perf_d = '0;
        cls    = '0;
        cur    = '0;
        upd    = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            cls = class_i[c*CLASS_W +: CLASS_W];
            for (int unsigned k = 0; k < N_CLASS; k++) begin
                if (valid_i[c] && (32'(cls) == k) && !flag_q[c][k]) begin
                    cur = 32'(cnt_q[c][k]);
                    if (error_i[c]) begin
                        upd = (cur + INC > CNT_MAX) ? CNT_MAX : cur + INC;
                    end else begin
                        upd = (cur > DEC) ? cur - DEC : '0;
                    end
                    // Crossing the threshold latches the flag and parks the counter at 0
                    if (upd >= THRESHOLD) begin
                        flag_d[c][k] = 1'b1;
                        cnt_d[c][k]  = '0;
                        perf_d[c]    = 1'b1;
                    end else begin
                        cnt_d[c][k]  = CNT_W'(upd);
                    end
                end
            end
        end
`ifdef CV32E40P_PERM_FAULT_CLEAR_EN
        // Soft clear overrides any same-cycle update and suppresses perf events
        if (clear_i) begin
            cnt_d  = '{default: '0};
            flag_d = '0;
            perf_d = '0;
        end
`endif
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '{default: '0};
            flag_q <= '0;
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            perf_q <= perf_d;
        end
    end

    // Per-channel summary of the sticky flags
    always_comb begin
        channel_faulty_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            channel_faulty_o[c] = |flag_q[c];
        end
    end

    assign permanent_faulty_o = flag_q;
    assign perf_event_o       = perf_q;

endmodule

// File: doc/cv32e40p_perm_fault_tracker_ft.md
# cv32e40p_perm_fault_tracker_ft

Parametrised permanent-fault tracker for the replicated ALUs of the fault-tolerant cv32e40p datapath. It keeps a leaky-bucket error counter for every (channel, operation class) pair. When a counter reaches its threshold, the pair is marked permanently faulty with a sticky flag and a one-cycle performance-counter event is raised. It sits beside the ALU voter in EX and feeds the ALU-selection logic and the performance counters.

## Interface
- N_CH, 4: number of monitored ALU channels.
- N_CLASS, 9: operation classes per channel (shift/add, logic, bitman, bitcount, shuffle, compare, abs/clip, min/max, div/rem).
- CNT_W, 8: counter width in bits.
- INC, 1: counter increment on an error.
- DEC, 2: counter decrement on an error-free operation.
- THRESHOLD, 101: count at or above which the pair is declared permanently faulty; must satisfy 1 ≤ THRESHOLD ≤ 2^CNT_W-1.
- CLASS_W, $clog2(N_CLASS): class index width (derived, not overridable).
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  N_CH  channel performed an operation this cycle.
- class_i  in  N_CH×CLASS_W  class index of that operation.
- error_i  in  N_CH  voter flagged this channel's result as wrong.
- clear_i  in  1  clear all flags and counters (see Configuration).
- permanent_faulty_o  out  N_CH×N_CLASS  sticky fault flags.
- channel_faulty_o  out  N_CH  OR of the channel's flags.
- perf_event_o  out  N_CH  one-cycle pulse when the channel gains a new faulty class.

## Operation
- Reset: all counters are 0, permanent_faulty_o=0, channel_faulty_o=0, perf_event_o=0.
- Per channel c, when valid_i[c]=1 and class k=class_i[c] is below N_CLASS, only counter (c,k) updates. Other counters hold their value.
- Error: cnt ← min(cnt+INC, 2^CNT_W-1), saturating with no wrap.
- No error: cnt ← (cnt > DEC) ? cnt-DEC : 0.
- If the updated value is ≥ THRESHOLD, then at the same edge flag (c,k) ← 1 and cnt ← 0.
- Once flag (c,k)=1, counter (c,k) is frozen at 0. Further valid_i or error_i for that pair is ignored.
- If class_i[c] ≥ N_CLASS, the operation is ignored and no state changes.
- valid_i[c]=0: no state change for channel c; error_i[c] is ignored.
- Channels are fully independent. Simultaneous events on all channels are all processed in the same cycle.
- perf_event_o[c] is registered. It is 1 for exactly one cycle, the first cycle in which a flag of channel c newly reads 1. It pulses again if another class of the same channel later becomes faulty.
- Flags never clear except on rst, or on clear_i when the macro is enabled.

## Timing
- Counter and flag update at the rising edge after valid_i is sampled, giving 1-cycle latency.
- permanent_faulty_o and perf_event_o change in the same cycle. channel_faulty_o is combinational from the flags.
- rst asserted mid-operation immediately zeros all state and outputs, with no clock needed. Deassertion is synchronised externally.
- If clear_i and valid_i are asserted in the same cycle, clear wins and the operation is dropped.

## Configuration
- Macro: CV32E40P_PERM_FAULT_CLEAR_EN.
- Defined: clear_i=1 zeros all counters and flags and perf_event_o at the next edge; this is a synchronous soft clear. No perf event is generated by the clear.
- Undefined: clear_i is ignored. Flags are cleared only by rst, and the same-cycle priority rule does not apply.

## Test plan
- Default parameters, ch0 class 1, 101 consecutive valid+error cycles:
  - flag[0][1] rises after the 101st edge.
  - perf_event_o=4'b0001 for one cycle.
  - channel_faulty_o[0]=1.
  - All other flags stay 0.
- Leaky bucket on ch2 class 5: 50 errors, then 10 clean operations, then errors.
  - Count is 50, then 30.
  - The flag sets only after 71 further errors.
- Saturation with CNT_W=4, THRESHOLD=15, INC=4: errors give counts 4, 8, 12, then 15 (saturated), and the flag sets on the 4th error. After that, the counter reads 0 and further errors have no effect.
- All 4 channels erroring simultaneously on different classes:
  - Independent counts.
  - 4 flags set on the same edge.
  - perf_event_o=4'b1111 for one cycle.
- Edge cases:
  - class_i=9 with error: no state change.
  - valid_i=0 with error_i=1: no change.
  - rst asserted mid-count (count 60): all state is 0 asynchronously.
- With CV32E40P_PERM_FAULT_CLEAR_EN, flag set, then clear_i together with valid+error: flags and counters are 0 next cycle and no perf event occurs. Without the macro, the flag persists.
